// File: rtl/poly_eval_fsm.sv
// Serial-load polynomial evaluator. Coefficients a_N..a_0 and then x are entered on DataIn,
// one Go press/release each. p(x) is evaluated by Horner's method on a single multiply/add path.
module poly_eval_fsm #(
   parameter  int WIDTH      = 8,
   parameter  int MAX_DEGREE = 4,
   localparam int DW         = (MAX_DEGREE < 1) ? 1 : $clog2(MAX_DEGREE + 1)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Go,
   input  logic [WIDTH-1:0] DataIn,
   input  logic [DW-1:0]    Degree,
   output logic [WIDTH-1:0] DataResult,
   output logic             ResultValid,
   output logic             Busy,
   output logic             Overflow
);

   // state            | meaning
   // S_LOAD_COEF      | wait for Go press, capture next coefficient (a_N first)
   // S_LOAD_COEF_WAIT | wait for Go release, advance coefficient index
   // S_LOAD_X         | wait for Go press, capture x
   // S_LOAD_X_WAIT    | wait for Go release, seed accumulator with a_N
   // S_MUL            | acc = acc * x (low WIDTH bits kept)
   // S_ADD            | acc = acc + a_i, count i down to 0
   typedef enum logic [2:0] {
      S_LOAD_COEF,
      S_LOAD_COEF_WAIT,
      S_LOAD_X,
      S_LOAD_X_WAIT,
      S_MUL,
      S_ADD
   } state_t;

   state_t             state;
   logic [DW-1:0]      idx;
   logic [DW-1:0]      n_deg;
   logic [DW-1:0]      i_cnt;
   logic [WIDTH-1:0]   coef [MAX_DEGREE+1];
   logic [WIDTH-1:0]   x_val;
   logic [WIDTH-1:0]   acc;
   logic [DW-1:0]      deg_clamp;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     sum;

   assign deg_clamp = (int'(Degree) > MAX_DEGREE) ? DW'(MAX_DEGREE) : Degree;
   assign prod      = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, x_val};
   assign sum       = {1'b0, acc} + {1'b0, coef[i_cnt]};

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= S_LOAD_COEF;
         idx         <= '0;
         n_deg       <= '0;
         i_cnt       <= '0;
         x_val       <= '0;
         acc         <= '0;
         for (int k = 0; k <= MAX_DEGREE; k++) coef[k] <= '0;
         DataResult  <= '0;
         ResultValid <= 1'b0;
         Busy        <= 1'b0;
         Overflow    <= 1'b0;
      end else begin
         case (state)
            S_LOAD_COEF: begin
               if (Go) begin
                  // first capture of a job fixes the degree and retires the previous result flags
                  if (idx == '0) begin
                     n_deg            <= deg_clamp;
                     coef[deg_clamp]  <= DataIn;
                     Overflow         <= 1'b0;
                     ResultValid      <= 1'b0;
                  end else begin
                     coef[n_deg - idx] <= DataIn;
                  end
                  state <= S_LOAD_COEF_WAIT;
               end
            end
            S_LOAD_COEF_WAIT: begin
               if (!Go) begin
                  if (idx == n_deg) begin
                     state <= S_LOAD_X;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= S_LOAD_COEF;
                  end
               end
            end
            S_LOAD_X: begin
               if (Go) begin
                  x_val <= DataIn;
                  state <= S_LOAD_X_WAIT;
               end
            end
            S_LOAD_X_WAIT: begin
               if (!Go) begin
                  acc   <= coef[n_deg];
                  i_cnt <= n_deg - 1'b1;
                  if (n_deg == '0) begin
                     DataResult  <= coef[n_deg];
                     ResultValid <= 1'b1;
                     idx         <= '0;
                     state       <= S_LOAD_COEF;
                  end else begin
                     Busy  <= 1'b1;
                     state <= S_MUL;
                  end
               end
            end
            S_MUL: begin
               acc <= prod[WIDTH-1:0];
               if (prod[2*WIDTH-1:WIDTH] != '0) Overflow <= 1'b1;
               state <= S_ADD;
            end
            S_ADD: begin
               acc <= sum[WIDTH-1:0];
               if (sum[WIDTH]) Overflow <= 1'b1;
               if (i_cnt == '0) begin
                  DataResult  <= sum[WIDTH-1:0];
                  ResultValid <= 1'b1;
                  Busy        <= 1'b0;
                  idx         <= '0;
                  state       <= S_LOAD_COEF;
               end else begin
                  i_cnt <= i_cnt - 1'b1;
                  state <= S_MUL;
               end
            end
            default: state <= S_LOAD_COEF;
         endcase
      end
   end

endmodule

// File: tb/tb_poly_eval_fsm.sv
// Bench for poly_eval_fsm: table of jobs run through a serial-load driver, results checked
// against a scoreboard queue when ResultValid rises, plus reset-abort and back-to-back sequences.
module tb_poly_eval_fsm;

   localparam int WIDTH = 8;
   localparam int MAXD  = 4;
   localparam int DW    = 3;

   logic             Clock = 1'b0;
   logic             Reset;
   logic             Go;
   logic [WIDTH-1:0] DataIn;
   logic [DW-1:0]    Degree;
   logic [WIDTH-1:0] DataResult;
   logic             ResultValid;
   logic             Busy;
   logic             Overflow;

   poly_eval_fsm #(.WIDTH(WIDTH), .MAX_DEGREE(MAXD)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Go          (Go),
      .DataIn      (DataIn),
      .Degree      (Degree),
      .DataResult  (DataResult),
      .ResultValid (ResultValid),
      .Busy        (Busy),
      .Overflow    (Overflow)
   );

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic [2:0]      deg;
      logic [4:0][7:0] c;
      logic [7:0]      x;
      logic [7:0]      res;
      logic            ovf;
   } vec_t;

   typedef struct packed {
      logic [7:0] res;
      logic       ovf;
   } exp_t;

   int         checks = 0;
   int         errors = 0;
   exp_t       sb[$];
   exp_t       mon_e;
   logic       prev_valid = 1'b0;
   logic [7:0] held = 8'h00;
   vec_t       tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic vec_t mk(input int deg, input int c0, input int c1, input int c2,
                               input int c3, input int c4, input int x, input int res,
                               input int ovf);
      vec_t v;
      v.deg  = 3'(deg);
      v.c[0] = 8'(c0);
      v.c[1] = 8'(c1);
      v.c[2] = 8'(c2);
      v.c[3] = 8'(c3);
      v.c[4] = 8'(c4);
      v.x    = 8'(x);
      v.res  = 8'(res);
      v.ovf  = 1'(ovf);
      return v;
   endfunction

   // scoreboard consumer: every rising ResultValid must match the oldest pending job
   always @(posedge Clock) begin
      #1;
      if (ResultValid && !prev_valid) begin
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_result actual=%0h required=none at %0t", DataResult, $time);
         end else begin
            mon_e = sb.pop_front();
            chk("result", 32'(DataResult), 32'(mon_e.res));
            chk("overflow", 32'(Overflow), 32'(mon_e.ovf));
         end
      end
      prev_valid = ResultValid;
   end

   task automatic run_job(input vec_t v, input bit toggle_busy, input bit abort);
      int ncoef;
      int n;
      int cycles;
      bit busy_seen;
      ncoef = (int'(v.deg) > MAXD) ? MAXD + 1 : int'(v.deg) + 1;
      n     = ncoef - 1;
      for (int k = 0; k < ncoef; k++) begin
         @(negedge Clock);
         DataIn = v.c[k];
         Go     = 1'b1;
         if (k == 0) Degree = v.deg;
         @(posedge Clock);
         #1;
         if (k == 0) begin
            chk("first_cap_valid_clr", 32'(ResultValid), 32'd0);
            chk("first_cap_ovf_clr", 32'(Overflow), 32'd0);
            chk("first_cap_result_held", 32'(DataResult), 32'(held));
            Degree = v.deg ^ 3'b101;
         end
         @(negedge Clock);
         DataIn = ~DataIn;
         @(negedge Clock);
         Go = 1'b0;
         @(posedge Clock);
      end
      sb.push_back({v.res, v.ovf});
      @(negedge Clock);
      DataIn = v.x;
      Go     = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      DataIn = ~DataIn;
      @(negedge Clock);
      Go = 1'b0;
      @(posedge Clock);
      #1;
      cycles    = 0;
      busy_seen = Busy;
      if (n == 0) begin
         chk("deg0_valid_on_release", 32'(ResultValid), 32'd1);
         chk("deg0_busy", 32'(Busy), 32'd0);
      end else begin
         while (!ResultValid && cycles < 100) begin
            if (abort && cycles == 2) begin
               Reset = 1'b1;
               #1;
               chk("abort_result", 32'(DataResult), 32'd0);
               chk("abort_valid", 32'(ResultValid), 32'd0);
               chk("abort_busy", 32'(Busy), 32'd0);
               chk("abort_ovf", 32'(Overflow), 32'd0);
               sb.delete();
               held = 8'h00;
               @(negedge Clock);
               Reset = 1'b0;
               return;
            end
            if (toggle_busy) begin
               Go     = (cycles < 2 * n - 2) ? ~Go : 1'b0;
               DataIn = 8'($urandom);
            end
            @(posedge Clock);
            #1;
            cycles++;
            if (Busy) busy_seen = 1'b1;
         end
         Go = 1'b0;
         chk("latency", 32'(cycles), 32'(2 * n));
         chk("busy_seen", 32'(busy_seen), 32'd1);
         chk("busy_end", 32'(Busy), 32'd0);
      end
      held = v.res;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout at %0t", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      tbl[0] = mk(2, 5, 4, 3, 0, 0, 2, 31, 0);
      tbl[1] = mk(3, 1, 0, 0, 0, 0, 7, 87, 1);
      tbl[2] = mk(0, 'hAB, 0, 0, 0, 0, 'h55, 'hAB, 0);
      tbl[3] = mk(7, 1, 1, 1, 1, 1, 2, 31, 0);
      tbl[4] = mk(1, 200, 100, 0, 0, 0, 2, 244, 1);
      tbl[5] = mk(4, 0, 0, 0, 0, 255, 0, 255, 0);
      tbl[6] = mk(1, 255, 1, 0, 0, 0, 1, 0, 1);

      Reset  = 1'b1;
      Go     = 1'b0;
      DataIn = '0;
      Degree = '0;
      #12;
      chk("reset_result", 32'(DataResult), 32'd0);
      chk("reset_valid", 32'(ResultValid), 32'd0);
      chk("reset_busy", 32'(Busy), 32'd0);
      chk("reset_ovf", 32'(Overflow), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;

      for (int t = 0; t < 7; t++) run_job(tbl[t], 1'b0, 1'b0);

      run_job(tbl[0], 1'b0, 1'b1);
      run_job(tbl[0], 1'b0, 1'b0);

      run_job(tbl[1], 1'b0, 1'b0);
      run_job(tbl[0], 1'b1, 1'b0);

      repeat (3) @(posedge Clock);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
